// File: rtl/task_dispatcher_if.sv
// Core-side bus of the task dispatcher: per-core enqueue strobes and queue
// numbers flowing in, per-core PC grants flowing out.
//   master : the dispatcher (drives set_pc/new_pc)
//   slave  : the core array (drives queue_wen/queue_number/request_new_pc)
interface task_dispatcher_if #(
    parameter int unsigned NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    queue_wen;
    logic [4*NUM_CORES-1:0]  queue_number;
    logic [NUM_CORES-1:0]    request_new_pc;
    logic [NUM_CORES-1:0]    set_pc;
    logic [16*NUM_CORES-1:0] new_pc;

    modport master (
        input  queue_wen,
        input  queue_number,
        input  request_new_pc,
        output set_pc,
        output new_pc
    );

    modport slave (
        output queue_wen,
        output queue_number,
        output request_new_pc,
        input  set_pc,
        input  new_pc
    );
endinterface

// File: rtl/task_dispatcher.sv
// Task dispatcher: turns per-core queue writes into start PCs via a 16-entry
// entry table, buffers them in a circular task FIFO, and hands them out
// round-robin to idle cores with a registered one-cycle grant.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cores (master)        : queue_wen/queue_number/request_new_pc in,
//                           set_pc/new_pc out (registered)
//   tbl_wen/waddr/wval    : entry-table write port
//   pending_count         : tasks held in the FIFO
//   overflow              : sticky, set when a push is dropped
//   idle                  : FIFO empty, all cores requesting, no grant visible
module task_dispatcher #(
    parameter int unsigned NUM_CORES  = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] BOOT_PC    = 16'h0000
) (
    input  logic                          clk,
    input  logic                          reset,
    task_dispatcher_if.master             cores,
    input  logic                          tbl_wen,
    input  logic [3:0]                    tbl_waddr,
    input  logic [15:0]                   tbl_wval,
    output logic [$clog2(FIFO_DEPTH):0]   pending_count,
    output logic                          overflow,
    output logic                          idle
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [15:0]             tbl [16];
    logic [15:0]             fifo [FIFO_DEPTH];
    logic [PW-1:0]           head;
    logic [PW-1:0]           tail;
    logic [CW-1:0]           count;
    logic [RW-1:0]           rr_ptr;
    logic [NUM_CORES-1:0]    set_pc_q;
    logic [16*NUM_CORES-1:0] new_pc_q;
    logic                    overflow_q;

    logic [NUM_CORES-1:0]    push_ok;
    logic [PW-1:0]           push_slot [NUM_CORES];
    logic [CW-1:0]           push_num;
    logic                    push_drop;

    logic [NUM_CORES-1:0]    eligible;
    logic                    gnt_valid;
    logic [RW-1:0]           gnt_sel;

    // Push acceptance: lowest core index first, against space before any pop.
    always_comb begin
        int unsigned acc;
        int unsigned free;
        push_ok   = '0;
        push_drop = 1'b0;
        acc       = 0;
        free      = FIFO_DEPTH - 32'(count);
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            push_slot[i] = PW'((32'(tail) + acc) % FIFO_DEPTH);
            if (cores.queue_wen[i]) begin
                if (acc < free) begin
                    push_ok[i] = 1'b1;
                    acc        = acc + 1;
                end else begin
                    push_drop = 1'b1;
                end
            end
        end
        push_num = CW'(acc);
    end

    // Round-robin pick among eligible cores; a core whose grant is visible
    // this cycle is excluded so it cannot be granted twice.
    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_sel   = '0;
        eligible  = cores.request_new_pc & ~set_pc_q;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_CORES;
            if (!gnt_valid && count != '0 && eligible[RW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_sel   = RW'(idx);
            end
        end
    end

    // State update: table, FIFO, grant outputs, round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                tbl[i] <= '0;
            end
            fifo[0]    <= BOOT_PC;
            head       <= '0;
            tail       <= PW'(1 % FIFO_DEPTH);
            count      <= CW'(1);
            rr_ptr     <= '0;
            set_pc_q   <= '0;
            new_pc_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pushes below read the table value from before this write.
            if (tbl_wen) begin
                tbl[tbl_waddr] <= tbl_wval;
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (push_ok[i]) begin
                    fifo[push_slot[i]] <= tbl[cores.queue_number[4*i +: 4]];
                end
            end
            tail     <= PW'((32'(tail) + 32'(push_num)) % FIFO_DEPTH);
            count    <= count + push_num - CW'(gnt_valid);
            set_pc_q <= '0;
            if (gnt_valid) begin
                set_pc_q[gnt_sel]                  <= 1'b1;
                new_pc_q[16*32'(gnt_sel) +: 16]    <= fifo[head];
                head                               <= PW'((32'(head) + 1) % FIFO_DEPTH);
                rr_ptr                             <= RW'((32'(gnt_sel) + 1) % NUM_CORES);
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign cores.set_pc  = set_pc_q;
    assign cores.new_pc  = new_pc_q;
    assign pending_count = count;
    assign overflow      = overflow_q;
    assign idle          = (count == '0) && (&cores.request_new_pc) && (set_pc_q == '0);
endmodule

// File: tb/tb_task_dispatcher.sv
// Bench for task_dispatcher: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_task_dispatcher;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [15:0] BOOT  = 16'h0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        tbl_wen;
    logic [3:0]  tbl_waddr;
    logic [15:0] tbl_wval;
    logic [4:0]  pending_count;
    logic        overflow;
    logic        idle;

    int checks = 0;
    int errors = 0;

    task_dispatcher_if #(.NUM_CORES(N)) bus ();

    task_dispatcher #(
        .NUM_CORES (N),
        .FIFO_DEPTH(DEPTH),
        .BOOT_PC   (BOOT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cores        (bus),
        .tbl_wen      (tbl_wen),
        .tbl_waddr    (tbl_waddr),
        .tbl_wval     (tbl_wval),
        .pending_count(pending_count),
        .overflow     (overflow),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_q[$];
    logic [15:0] m_tbl [16];
    logic [15:0] m_newpc [N];
    logic [N-1:0] m_set;
    int          m_rr;
    logic        m_ovf;
    bit          m_valid = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of specification behaviour, from current state and inputs.
    task automatic model_update();
        int sel;
        int free;
        int acc;
        logic [15:0] pc;
        if (reset) begin
            m_q.delete();
            m_q.push_back(BOOT);
            for (int i = 0; i < 16; i++) m_tbl[i] = '0;
            for (int i = 0; i < N; i++) m_newpc[i] = '0;
            m_set   = '0;
            m_rr    = 0;
            m_ovf   = 1'b0;
            m_valid = 1;
            return;
        end
        sel = -1;
        if (m_q.size() > 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (sel < 0 && bus.request_new_pc[c] && !m_set[c]) sel = c;
            end
        end
        free = DEPTH - m_q.size();
        pc   = '0;
        if (sel >= 0) pc = m_q.pop_front();
        acc = 0;
        for (int i = 0; i < N; i++) begin
            if (bus.queue_wen[i]) begin
                if (acc < free) begin
                    m_q.push_back(m_tbl[bus.queue_number[4*i +: 4]]);
                    acc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (tbl_wen) m_tbl[tbl_waddr] = tbl_wval;
        m_set = '0;
        if (sel >= 0) begin
            m_set[sel]   = 1'b1;
            m_newpc[sel] = pc;
            m_rr         = (sel + 1) % N;
        end
    endtask

    // Advance one cycle with the inputs currently driven, then compare.
    task automatic step();
        logic [63:0] exp_pc;
        #1;
        if (m_valid && !reset)
            check("idle", 64'(idle), 64'((m_q.size() == 0) && (&bus.request_new_pc) && (m_set == '0)));
        model_update();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) exp_pc[16*i +: 16] = m_newpc[i];
        check("set_pc", 64'(bus.set_pc), 64'(m_set));
        check("new_pc", bus.new_pc, exp_pc);
        check("pending_count", 64'(pending_count), 64'(m_q.size()));
        check("overflow", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic drive(input logic [3:0] wen, input logic [15:0] qn, input logic [3:0] rq);
        bus.queue_wen      = wen;
        bus.queue_number   = qn;
        bus.request_new_pc = rq;
        step();
        tbl_wen = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic tbl_write(input logic [3:0] a, input logic [15:0] v);
        tbl_wen   = 1'b1;
        tbl_waddr = a;
        tbl_wval  = v;
        drive(4'h0, 16'h0000, 4'h0);
    endtask

    initial begin
        reset              = 1'b1;
        tbl_wen            = 1'b0;
        tbl_waddr          = '0;
        tbl_wval           = '0;
        bus.queue_wen      = '0;
        bus.queue_number   = '0;
        bus.request_new_pc = '0;

        // Boot: one grant of BOOT_PC to core 0
        reset = 1'b1;
        drive(4'h0, 16'h0000, 4'hF);
        check("rst_set_pc", 64'(bus.set_pc), 64'h0);
        check("rst_pending", 64'(pending_count), 64'd1);
        drive(4'h0, 16'h0000, 4'hF);
        check("boot_set_pc", 64'(bus.set_pc), 64'h1);
        check("boot_new_pc0", 64'(bus.new_pc[15:0]), 64'h0010);
        check("boot_pending", 64'(pending_count), 64'd0);
        drive(4'h0, 16'h0000, 4'hF);
        check("boot_single", 64'(bus.set_pc), 64'h0);
        #1;
        check("boot_idle", 64'(idle), 64'd1);

        // Table and push
        tbl_write(4'd3, 16'h0040);
        drive(4'h1, 16'h0003, 4'h4);
        check("push_pending", 64'(pending_count), 64'd1);
        drive(4'h0, 16'h0000, 4'h4);
        check("push_set_pc", 64'(bus.set_pc), 64'h4);
        check("push_new_pc2", 64'(bus.new_pc[47:32]), 64'h0040);
        drive(4'h0, 16'h0000, 4'h0);

        // Fairness: realign rr to core 0 by granting the boot task to core 3
        reset = 1'b1;
        drive(4'h0, 16'h0000, 4'h0);
        drive(4'h0, 16'h0000, 4'h8);
        for (int i = 1; i <= 4; i++) tbl_write(4'(i), 16'h0100 + 16'(i));
        drive(4'hF, 16'h4321, 4'hF);
        check("fair_pending", 64'(pending_count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] pcs;
            drive(4'h0, 16'h0000, 4'hF);
            pcs = bus.new_pc;
            check("fair_set_pc", 64'(bus.set_pc), 64'(4'b0001 << i));
            check("fair_new_pc", 64'(pcs[16*i +: 16]), 64'h0101 + 64'(i));
        end

        // Same-cycle table write vs push: push sees the old entry
        tbl_write(4'd5, 16'h0005);
        tbl_wen = 1'b1; tbl_waddr = 4'd5; tbl_wval = 16'h0ABC;
        drive(4'h2, 16'h0050, 4'h0);
        drive(4'h0, 16'h0000, 4'h1);
        check("haz_new_pc0", 64'(bus.new_pc[15:0]), 64'h0005);
        drive(4'h0, 16'h0000, 4'h0);

        // Overflow: fill to 15, then 3 pushes in one cycle
        reset = 1'b1;
        drive(4'h0, 16'h0000, 4'h0);
        for (int i = 0; i < 3; i++) drive(4'hF, 16'h0000, 4'h0);
        drive(4'h3, 16'h0000, 4'h0);
        check("ovf_fill", 64'(pending_count), 64'd15);
        drive(4'h7, 16'h0000, 4'h0);
        check("ovf_pending", 64'(pending_count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        drive(4'h1, 16'h0000, 4'h1);
        check("ovf_pop_push", 64'(pending_count), 64'd15);
        for (int i = 0; i < 30; i++) drive(4'h0, 16'h0000, 4'hF);
        check("ovf_drained", 64'(pending_count), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-operation
        drive(4'hF, 16'h0000, 4'h0);
        drive(4'h1, 16'h0000, 4'h0);
        check("mid_pending", 64'(pending_count), 64'd5);
        reset = 1'b1;
        drive(4'h0, 16'h0000, 4'hF);
        check("mid_set_pc", 64'(bus.set_pc), 64'h0);
        check("mid_pending_rst", 64'(pending_count), 64'd1);
        drive(4'h0, 16'h0000, 4'h1);
        check("mid_boot_pc", 64'(bus.new_pc[15:0]), 64'(BOOT));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tbl_wen   = ($urandom % 6) == 0;
            tbl_waddr = 4'($urandom);
            tbl_wval  = 16'($urandom);
            reset     = ($urandom % 400) == 0;
            drive(4'($urandom) & 4'($urandom) & (4'($urandom) | 4'($urandom)),
                  16'($urandom),
                  4'($urandom) | 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Feeds program counters to the array of `processor` cores and consumes their queue writes. Each core's `queue_wen`/`queue_number` pulse enqueues a task whose start PC comes from a programmable 16-entry entry table. Cores asserting `request_new_pc` are served round-robin from a shared task FIFO with a one-cycle `set_pc`/`new_pc` grant. After reset the FIFO holds a single boot task, so exactly one core starts execution.

## Interface
- `NUM_CORES`, default 4: number of attached cores, 1..8.
- `FIFO_DEPTH`, default 16: task FIFO capacity, power of two, ≥ `NUM_CORES`.
- `BOOT_PC`, default 16'h0000: PC of the task preloaded at reset.

- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `queue_wen` in NUM_CORES: per-core enqueue strobe, 1-cycle pulse, no backpressure.
- `queue_number` in 4*NUM_CORES: per-core queue number; core i uses bits [4i+3:4i].
- `request_new_pc` in NUM_CORES: per-core level, high while the core is idle and wants a task.
- `set_pc` out NUM_CORES: per-core grant pulse, registered.
- `new_pc` out 16*NUM_CORES: per-core granted PC, registered; core i uses bits [16i+15:16i].
- `tbl_wen` in 1: entry-table write strobe.
- `tbl_waddr` in 4: entry-table index.
- `tbl_wval` in 16: entry-table start PC.
- `pending_count` out clog2(FIFO_DEPTH)+1: tasks currently in the FIFO.
- `overflow` out 1: sticky; set when any push is dropped.
- `idle` out 1: FIFO empty, every core requesting, and no grant outstanding.

## Operation
- Entry table: 16×16 registers, all zero after reset. Pushes read the table before any same-cycle `tbl_wen` write takes effect, so they get the old value.
- Push: each cycle, every core with `queue_wen` high pushes `table[queue_number_i]`. Pushes are ordered by ascending core index. Free space is `FIFO_DEPTH - pending_count`, sampled before any same-cycle pop; the pop does not create room for this cycle's pushes. Pushes beyond free space are dropped, highest index first, and each drop sets `overflow`.
- FIFO: circular buffer with a head pointer and a tail pointer, each wrapping modulo `FIFO_DEPTH`. Up to `NUM_CORES` writes and 1 read per cycle. `pending_count` updates as count + accepted pushes − pop.
- Eligibility: core i is eligible when `request_new_pc[i]` is high and `set_pc[i]` is low in the current cycle. The second condition prevents re-granting a core during the cycle its grant is visible.
- Grant: if the FIFO is non-empty, at most one eligible core is selected per cycle by round-robin. The search starts at `rr_ptr` and wraps around. On the clock edge:
  - the head entry is popped;
  - `set_pc[sel]` and `new_pc[sel]` are registered;
  - `rr_ptr` becomes `sel+1` modulo `NUM_CORES`.
- Output hold and clear: `new_pc[i]` holds its last value when not granted. `set_pc` bits clear on the next edge unless that core is re-granted, which eligibility forbids.
- Empty FIFO: no pop, no grant, `rr_ptr` unchanged.
- A task pushed at edge t is first poppable in cycle t+1. There is no push-to-pop bypass.
- Reset: FIFO holds one entry `BOOT_PC`, so `pending_count`=1. Also `set_pc`=0, all `new_pc`=0, `overflow`=0, `rr_ptr`=0, table all 0. Reset in mid-operation discards queued tasks and any grant being formed that cycle. Reset wins over every same-cycle push, pop and table write.

## Timing
- Request to grant: if core i is eligible and selected in cycle t, `set_pc[i]`=1 and `new_pc[i]` is valid for all of cycle t+1. The core samples the grant at the end of t+1 and drops `request_new_pc` in t+2.
- Back-to-back: with one requesting core, grants occur every 2 cycles at most. With N requesting cores, one grant per cycle.
- Push to pending: `queue_wen` in cycle t gives an updated `pending_count` in t+1. The earliest grant of that task is in cycle t+1, with `set_pc` in t+2.
- Table write in cycle t affects pushes from cycle t+1 onward.
- Release from reset: the first cycle after `reset` falls with core 0 requesting gives `set_pc[0]`=1, `new_pc[0]`=`BOOT_PC` in the following cycle.
- `idle`: combinational from registered state and inputs.

## Test plan
- **Boot:** reset, all 4 cores requesting, BOOT_PC=16'h0010 → exactly one grant: `set_pc`=4'b0001, `new_pc[0]`=16'h0010; `pending_count` goes 1→0.
- **Table and push:** write table[3]=16'h0040; core 0 pushes queue 3 → `pending_count`=1 next cycle; requesting core 2 then gets `new_pc[2]`=16'h0040 two cycles after the push.
- **Simultaneous push and fairness:** in one cycle cores 0–3 push queues 1,2,3,4 (table 16'h0101..16'h0104) with all cores requesting → one grant per cycle to cores 0,1,2,3 with PCs 16'h0101..16'h0104 in order.
- **Overflow:** fill to 15 of 16, then 3 cores push in one cycle → only the lowest-index push is accepted, `pending_count`=16, `overflow`=1 and stays 1 after the FIFO drains.
- **Same-cycle hazards:**
  - `tbl_wen` table[5]=16'h0ABC in the same cycle core 1 pushes queue 5 (old value 16'h0005) → the enqueued task is 16'h0005.
  - A pop in the same cycle as a push at full → the push is dropped.
- **Reset mid-operation:** 5 tasks queued with a grant forming → assert reset for 1 cycle → `set_pc`=0 and `pending_count`=1, and the next grant carries `BOOT_PC`.
